// File: rtl/uds_tile_loader.sv
// uds_tile_loader: gathers ROWS x 256-bit rows into one tile, issues it on idata and then
// drives the engine's active window. Define UDS_LOADER_PINGPONG_EN for a second tile buffer.
module uds_tile_loader #(
  parameter int ROWS          = 8,
  parameter int ACTIVE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [255:0]          in_row,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [1:0]            cfg_scale,
  input  logic [1:0]            cfg_mode,
  output logic [ROWS*256-1:0]   idata,
  output logic                  idata_valid,
  output logic                  active,
  output logic [1:0]            scale_factor,
  output logic [1:0]            function_mode,
  output logic                  pad_flag,
  output logic [15:0]           tile_count
);

`ifdef UDS_LOADER_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {FILL, ISSUE, ACT, GAP} state_t;

  state_t         state;
  logic [3:0]     timer;
  logic [RW-1:0]  row_cnt;
  logic           ready_en;
  logic           wr_sel, rd_sel;
  logic [1:0]     full;

  logic [255:0]   tile_buf  [2][ROWS];
  logic [1:0]     scale_buf [2];
  logic [1:0]     mode_buf  [2];
  logic           pad_buf   [2];

  logic accept, last_row, fin, can_issue, issue_buf, issue_direct, store_fin;
  logic [ROWS*256-1:0] direct_tile, stored_tile;

  assign accept    = in_valid & in_ready;
  assign last_row  = (row_cnt == RW'(ROWS - 1));
  assign fin       = accept & (in_last | last_row);
  assign can_issue = (state == FILL) || (state == GAP && timer == 4'd0);
  // A completed pending buffer takes priority over a tile finishing this very cycle.
  assign issue_buf    = PINGPONG && can_issue && full[rd_sel];
  assign issue_direct = can_issue && !issue_buf && fin;
  assign store_fin    = fin && !issue_direct;
  assign in_ready     = ready_en & (PINGPONG ? !(full[0] & full[1]) : (state == FILL));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    direct_tile = '0;
    stored_tile = '0;
    for (int k = 0; k < ROWS; k++) begin
      stored_tile[k*256 +: 256] = tile_buf[rd_sel][k];
      if (k == int'(row_cnt))
        direct_tile[k*256 +: 256] = in_row;
      else if (k < int'(row_cnt))
        direct_tile[k*256 +: 256] = tile_buf[wr_sel][k];
    end
  end

  // NOTE: tile storage has no reset; each row is written or zero-filled before it can be issued.
  always_ff @(posedge clk) begin
    if (accept) begin
      tile_buf[wr_sel][row_cnt] <= in_row;
      if (row_cnt == '0) begin
        scale_buf[wr_sel] <= cfg_scale;
        mode_buf[wr_sel]  <= cfg_mode;
      end
    end
    if (store_fin) begin
      pad_buf[wr_sel] <= !last_row;
      for (int k = 0; k < ROWS; k++)
        if (k > int'(row_cnt)) tile_buf[wr_sel][k] <= '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      timer         <= '0;
      row_cnt       <= '0;
      ready_en      <= 1'b0;
      wr_sel        <= 1'b0;
      rd_sel        <= 1'b0;
      full          <= '0;
      idata         <= '0;
      idata_valid   <= 1'b0;
      active        <= 1'b0;
      scale_factor  <= '0;
      function_mode <= '0;
      pad_flag      <= 1'b0;
      tile_count    <= '0;
    end else begin
      ready_en    <= 1'b1;
      idata_valid <= 1'b0;

      if (accept)
        row_cnt <= fin ? '0 : row_cnt + 1'b1;

      if (store_fin) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end

      if (issue_buf || issue_direct) begin
        state       <= ISSUE;
        idata_valid <= 1'b1;
        tile_count  <= tile_count + 16'd1;
        if (issue_buf) begin
          idata         <= stored_tile;
          scale_factor  <= scale_buf[rd_sel];
          function_mode <= mode_buf[rd_sel];
          pad_flag      <= pad_buf[rd_sel];
          full[rd_sel]  <= 1'b0;
          rd_sel        <= ~rd_sel;
        end else begin
          idata         <= direct_tile;
          scale_factor  <= (row_cnt == '0) ? cfg_scale : scale_buf[wr_sel];
          function_mode <= (row_cnt == '0) ? cfg_mode  : mode_buf[wr_sel];
          pad_flag      <= !last_row;
        end
      end else begin
        case (state)
          FILL: ;
          ISSUE: begin
            state  <= ACT;
            active <= 1'b1;
            timer  <= 4'(ACTIVE_CYCLES - 1);
          end
          ACT: begin
            if (timer == 4'd0) begin
              state  <= GAP;
              active <= 1'b0;
              timer  <= 4'd1;
            end else begin
              timer <= timer - 4'd1;
            end
          end
          GAP: begin
            if (timer == 4'd0) state <= FILL;
            else               timer <= timer - 4'd1;
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uds_tile_loader.sv
// Directed self-checking bench for uds_tile_loader (ROWS=8, ACTIVE_CYCLES=2).
module tb_uds_tile_loader;

`ifdef UDS_LOADER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [255:0]  in_row;
  logic          in_valid, in_last, in_ready;
  logic [1:0]    cfg_scale, cfg_mode;
  logic [2047:0] idata;
  logic          idata_valid, active, pad_flag;
  logic [1:0]    scale_factor, function_mode;
  logic [15:0]   tile_count;

  int n_checks = 0;
  int n_pass   = 0;

  uds_tile_loader #(.ROWS(8), .ACTIVE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_row(in_row), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .cfg_scale(cfg_scale), .cfg_mode(cfg_mode), .idata(idata),
    .idata_valid(idata_valid), .active(active), .scale_factor(scale_factor),
    .function_mode(function_mode), .pad_flag(pad_flag), .tile_count(tile_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] mk_row(input logic [31:0] base);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = base + 32'(j);
    return r;
  endfunction

  function automatic logic [31:0] item(input int k, input int j);
    return idata[k*256 + j*32 +: 32];
  endfunction

  // Drive one row at the current negedge; it is accepted on the following posedge.
  task automatic send(input logic [255:0] row, input logic last, input logic [1:0] sc,
                      input logic [1:0] md);
    in_row = row; in_last = last; cfg_scale = sc; cfg_mode = md; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int acc, stall, cyc, iss_n;
    int iss_cyc [2];
    logic [1:0] sc_at_iss;
    logic ok;

    rst_n = 1'b0; in_row = '0; in_valid = 1'b0; in_last = 1'b0; cfg_scale = '0; cfg_mode = '0;

    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_idata_valid", 64'(idata_valid), 64'd0);
    check("rst_active", 64'(active), 64'd0);
    check("rst_tile_count", 64'(tile_count), 64'd0);
    check("rst_idata", idata[63:0], 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Full tile: row k items k*8+j, mode 2'b10
    for (int k = 0; k < 8; k++) send(mk_row(32'(k*8)), 1'b0, 2'd0, 2'b10);
    check("t1_idata_valid", 64'(idata_valid), 64'd1);
    check("t1_active_at_issue", 64'(active), 64'd0);
    check("t1_in_ready_issue", 64'(in_ready), 64'(PP));
    check("t1_mode", 64'(function_mode), 64'd2);
    check("t1_pad", 64'(pad_flag), 64'd0);
    check("t1_count", 64'(tile_count), 64'd1);
    ok = 1'b1;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 8; j++)
        if (item(k, j) !== 32'(k*8 + j)) ok = 1'b0;
    check("t1_all_items", 64'(ok), 64'd1);
    check("t1_item_3_5", 64'(item(3, 5)), 64'd29);
    @(negedge clk);
    check("t1_act1", 64'(active), 64'd1);
    check("t1_strobe_one_cycle", 64'(idata_valid), 64'd0);
    @(negedge clk);
    check("t1_act2", 64'(active), 64'd1);
    @(negedge clk);
    check("t1_gap1_active", 64'(active), 64'd0);
    check("t1_gap1_ready", 64'(in_ready), 64'(PP));
    @(negedge clk);
    check("t1_gap2_ready", 64'(in_ready), 64'(PP));
    @(negedge clk);
    check("t1_fill_ready", 64'(in_ready), 64'd1);
    check("t1_hold_item", 64'(item(7, 7)), 64'd63);

    // Early in_last on row 2
    for (int k = 0; k < 3; k++) send(mk_row(32'h1000 + 32'(k*8)), k == 2, 2'd2, 2'd1);
    check("t2_idata_valid", 64'(idata_valid), 64'd1);
    check("t2_pad", 64'(pad_flag), 64'd1);
    check("t2_row2", 64'(item(2, 0)), 64'h1010);
    ok = 1'b1;
    for (int k = 3; k < 8; k++)
      for (int j = 0; j < 8; j++)
        if (item(k, j) !== 32'd0) ok = 1'b0;
    check("t2_zero_fill", 64'(ok), 64'd1);
    check("t2_count", 64'(tile_count), 64'd2);
    repeat (5) @(negedge clk);
    wait_ready("t2_ready_again");

    // Back-to-back tiles, in_valid held high; row 0 of each has scale 1, others scale 3
    acc = 0; stall = 0; cyc = 0; iss_n = 0; sc_at_iss = 2'd0;
    iss_cyc[0] = 0; iss_cyc[1] = 0;
    in_valid = 1'b1;
    while (acc < 16 && cyc < 80) begin
      in_row = mk_row(32'h2000 + 32'(acc*8)); in_last = 1'b0;
      cfg_scale = (acc % 8 == 0) ? 2'd1 : 2'd3; cfg_mode = 2'd1;
      ok = in_ready;
      @(negedge clk);
      cyc++;
      if (ok) acc++; else stall++;
      if (idata_valid && iss_n < 2) begin
        iss_cyc[iss_n] = cyc;
        if (iss_n == 0) sc_at_iss = scale_factor;
        iss_n++;
      end
    end
    in_valid = 1'b0;
    check("t3_issues", 64'(iss_n), 64'd2);
    check("t3_first_issue", 64'(iss_cyc[0]), 64'd8);
    check("t3_stalls", 64'(stall), PP ? 64'd0 : 64'd5);
    check("t3_issue_gap", 64'(iss_cyc[1] - iss_cyc[0]), PP ? 64'd8 : 64'd13);
    check("t4_scale_row0", 64'(sc_at_iss), 64'd1);
    check("t3_t2_item", 64'(item(1, 2)), 64'h204A);
    check("t3_mode", 64'(function_mode), 64'd1);
    check("t3_count", 64'(tile_count), 64'd4);
    repeat (5) @(negedge clk);
    wait_ready("t3_ready_again");

    // Reset while row 4 is being presented
    for (int k = 0; k < 4; k++) send(mk_row(32'h3000 + 32'(k*8)), 1'b0, 2'd2, 2'd2);
    in_row = mk_row(32'h3020); in_valid = 1'b1; rst_n = 1'b0;
    #2;
    check("t5_rst_ready", 64'(in_ready), 64'd0);
    check("t5_rst_count", 64'(tile_count), 64'd0);
    check("t5_rst_scale", 64'(scale_factor), 64'd0);
    check("t5_rst_mode", 64'(function_mode), 64'd0);
    check("t5_rst_idata", idata[2047:1984], 64'd0);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) send(mk_row(32'h4000 + 32'(k*8)), 1'b0, 2'd0, 2'd3);
    check("t5_idata_valid", 64'(idata_valid), 64'd1);
    check("t5_count", 64'(tile_count), 64'd1);
    check("t5_row0", 64'(item(0, 0)), 64'h4000);
    check("t5_row4", 64'(item(4, 1)), 64'h4021);
    check("t5_pad", 64'(pad_flag), 64'd0);
    check("t5_mode", 64'(function_mode), 64'd3);
    repeat (5) @(negedge clk);
    wait_ready("t5_ready_again");

    // in_last without in_valid is ignored
    in_last = 1'b1;
    @(negedge clk);
    in_last = 1'b0;
    @(negedge clk);
    check("t6_stray_last", 64'(idata_valid), 64'd0);

    // tile_count wrap
    force dut.tile_count = 16'hFFFF;
    @(negedge clk);
    release dut.tile_count;
    check("t6_preload", 64'(tile_count), 64'hFFFF);
    for (int k = 0; k < 8; k++) send(mk_row(32'h5000 + 32'(k*8)), 1'b0, 2'd0, 2'd0);
    check("t6_issue", 64'(idata_valid), 64'd1);
    check("t6_wrap", 64'(tile_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
